// File: rtl/execute_stage.sv
// EX stage of the RV64 pipeline: operand forwarding, ALU, branch/jump resolve, EX/MEM register.
// Optional iterative MUL unit enabled by defining EXECUTE_MUL_EN.
module execute_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reg_write_e,
  input  logic            result_src_e,
  input  logic            mem_write_e,
  input  logic            jump_e,
  input  logic            branch_e,
  input  logic [2:0]      alu_control_e,
  input  logic            alu_src_e,
  input  logic            mul_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [4:0]      rd_e,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] result_w,
  input  logic            flush_e,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            stall_e,
  output logic            reg_write_m,
  output logic            result_src_m,
  output logic            mem_write_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [4:0]      rd_m
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] exec_result;
  logic            slt;

  always_comb begin
    case (forward_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    case (forward_b_e)
      2'b01:   write_data = result_w;
      2'b10:   write_data = alu_result_m;
      default: write_data = rd2_e;
    endcase
    src_b = alu_src_e ? imm_ext_e : write_data;
  end

  assign slt = $signed(src_a) < $signed(src_b);

  always_comb begin
    case (alu_control_e)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, slt};
      3'b110:  alu_result = src_a << src_b[SHW-1:0];
      default: alu_result = src_a >> src_b[SHW-1:0];
    endcase
  end

  // Redirect is left ungated by flush; the hazard unit qualifies it.
  assign pc_src_e    = jump_e | (branch_e & (alu_result == '0));
  assign pc_target_e = pc_e + imm_ext_e;

`ifdef EXECUTE_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_t;

  mul_state_t      state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplr_q, mplr_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic            mul_done;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    stall_e  = 1'b0;
    mul_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mul_e && !flush_e) begin
          state_d = S_RUN;
          mcand_d = src_a;
          mplr_d  = src_b;
          acc_d   = '0;
          cnt_d   = '0;
          stall_e = 1'b1;
        end
      end
      S_RUN: begin
        stall_e = 1'b1;
        if (flush_e) begin
          state_d = S_IDLE;
        end else begin
          // Only the low XLEN product bits are kept, so the accumulator never widens.
          if (mplr_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN-1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        mul_done = !flush_e;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
    end
  end

  assign exec_result = mul_done ? acc_q : alu_result;
`else
  logic unused_mul;
  assign unused_mul  = mul_e;
  assign stall_e     = 1'b0;
  assign exec_result = alu_result;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || flush_e || stall_e) begin
      reg_write_m  <= 1'b0;
      result_src_m <= 1'b0;
      mem_write_m  <= 1'b0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
    end else begin
      reg_write_m  <= reg_write_e;
      result_src_m <= result_src_e;
      mem_write_m  <= mem_write_e;
      alu_result_m <= exec_result;
      write_data_m <= write_data;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed spec cases plus randomized stream vs a reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n, reg_write_e, result_src_e, mem_write_e, jump_e, branch_e;
  logic [2:0]  alu_control_e;
  logic        alu_src_e, mul_e, flush_e;
  logic [63:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e, result_w;
  logic [4:0]  rd_e;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        pc_src_e, stall_e, reg_write_m, result_src_m, mem_write_m;
  logic [63:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
    .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .mul_e(mul_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .imm_ext_e(imm_ext_e), .rd_e(rd_e), .forward_a_e(forward_a_e),
    .forward_b_e(forward_b_e), .result_w(result_w), .flush_e(flush_e),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .stall_e(stall_e),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .mem_write_m(mem_write_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .pc_plus4_m(pc_plus4_m), .rd_m(rd_m)
  );

  typedef struct {
    logic        rst_n, reg_write, result_src, mem_write, jump, branch, alu_src, mul, flush;
    logic [2:0]  ctl;
    logic [63:0] rd1, rd2, pc, pc4, imm, res_w;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
  } stim_t;

  typedef struct {
    logic        reg_write, result_src, mem_write;
    logic [63:0] alu, wdata, pc4;
    logic [4:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_alu_m = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [63:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] ctl);
    case (ctl)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd6: return a << (b % 64);
      default: return a >> (b % 64);
    endcase
  endfunction

  function automatic logic [63:0] fwd(input logic [1:0] sel, input logic [63:0] r,
                                      input logic [63:0] w, input logic [63:0] m);
    if (sel == 2'b01) return w;
    if (sel == 2'b10) return m;
    return r;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{rst_n: 1'b1, reg_write: 1'b0, result_src: 1'b0, mem_write: 1'b0, jump: 1'b0,
          branch: 1'b0, alu_src: 1'b0, mul: 1'b0, flush: 1'b0, ctl: 3'd0, rd1: '0, rd2: '0,
          pc: '0, pc4: '0, imm: '0, res_w: '0, rd: '0, fa: 2'b00, fb: 2'b00};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s            = nop();
    s.rst_n      = ($urandom_range(31) != 0);
    s.flush      = ($urandom_range(7) == 0);
    s.reg_write  = $urandom_range(1);
    s.result_src = $urandom_range(1);
    s.mem_write  = $urandom_range(1);
    s.jump       = ($urandom_range(7) == 0);
    s.branch     = $urandom_range(1);
    s.alu_src    = $urandom_range(1);
`ifndef EXECUTE_MUL_EN
    s.mul        = $urandom_range(1);
`endif
    s.ctl        = 3'($urandom_range(7));
    s.rd1        = ($urandom_range(1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(15));
    s.rd2        = ($urandom_range(3) == 0) ? s.rd1 : {$urandom, $urandom};
    s.pc         = {$urandom, $urandom};
    s.pc4        = s.pc + 64'd4;
    s.imm        = ($urandom_range(1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(127));
    s.res_w      = {$urandom, $urandom};
    s.rd         = 5'($urandom_range(31));
    s.fa         = 2'($urandom_range(3));
    s.fb         = 2'($urandom_range(3));
    return s;
  endfunction

  // Apply one cycle of stimulus, queue the EX/MEM value expected after the edge,
  // check the combinational outputs, then advance to the next falling edge.
  task automatic drive(input stim_t s, input logic exp_stall, input logic mul_done);
    logic [63:0] a, wd, b, r;
    logic        bubble, exp_pc_src;
    exp_t        e;
    rst_n = s.rst_n; reg_write_e = s.reg_write; result_src_e = s.result_src;
    mem_write_e = s.mem_write; jump_e = s.jump; branch_e = s.branch;
    alu_control_e = s.ctl; alu_src_e = s.alu_src; mul_e = s.mul; flush_e = s.flush;
    rd1_e = s.rd1; rd2_e = s.rd2; pc_e = s.pc; pc_plus4_e = s.pc4; imm_ext_e = s.imm;
    result_w = s.res_w; rd_e = s.rd; forward_a_e = s.fa; forward_b_e = s.fb;
    a  = fwd(s.fa, s.rd1, s.res_w, model_alu_m);
    wd = fwd(s.fb, s.rd2, s.res_w, model_alu_m);
    b  = s.alu_src ? s.imm : wd;
    r  = alu_ref(a, b, s.ctl);
    exp_pc_src = s.jump || (s.branch && (r == 64'd0));
    bubble = !s.rst_n || s.flush || exp_stall;
    if (bubble) e = '{reg_write: 1'b0, result_src: 1'b0, mem_write: 1'b0,
                      alu: '0, wdata: '0, pc4: '0, rd: '0};
    else e = '{reg_write: s.reg_write, result_src: s.result_src, mem_write: s.mem_write,
               alu: mul_done ? s.rd1 * s.rd2 : r, wdata: wd, pc4: s.pc4, rd: s.rd};
    exp_q.push_back(e);
    model_alu_m = e.alu;
    #1;
    n_tests++;
    if (pc_src_e !== exp_pc_src || pc_target_e !== s.pc + s.imm || stall_e !== exp_stall) begin
      n_fail++;
      $display("FAIL comb: pc_src=%0b pc_target=%h stall=%0b, required pc_src=%0b pc_target=%h stall=%0b",
               pc_src_e, pc_target_e, stall_e, exp_pc_src, s.pc + s.imm, exp_stall);
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (reg_write_m !== e.reg_write || result_src_m !== e.result_src ||
            mem_write_m !== e.mem_write || alu_result_m !== e.alu ||
            write_data_m !== e.wdata || pc_plus4_m !== e.pc4 || rd_m !== e.rd) begin
          n_fail++;
          $display("FAIL exmem @%0t: got rw=%0b rs=%0b mw=%0b alu=%h wd=%h pc4=%h rd=%0d, required rw=%0b rs=%0b mw=%0b alu=%h wd=%h pc4=%h rd=%0d",
                   $time, reg_write_m, result_src_m, mem_write_m, alu_result_m, write_data_m,
                   pc_plus4_m, rd_m, e.reg_write, e.result_src, e.mem_write, e.alu, e.wdata,
                   e.pc4, e.rd);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    s = nop(); s.rst_n = 1'b0;
    drive(s, 1'b0, 1'b0);
    drive(s, 1'b0, 1'b0);
    // ADD with immediate: 5 + 7
    s = nop(); s.rd1 = 64'd5; s.imm = 64'd7; s.alu_src = 1'b1; s.reg_write = 1'b1; s.rd = 5'd3;
    s.pc4 = 64'h104;
    drive(s, 1'b0, 1'b0);
    // Produce 100, then forward it from EX/MEM into a SUB
    s = nop(); s.rd1 = 64'd100; s.alu_src = 1'b1; s.reg_write = 1'b1; s.rd = 5'd4;
    drive(s, 1'b0, 1'b0);
    s = nop(); s.fa = 2'b10; s.rd2 = 64'd3; s.ctl = 3'd1; s.reg_write = 1'b1; s.rd = 5'd5;
    drive(s, 1'b0, 1'b0);
    s.fa = 2'b01; s.res_w = 64'd9;
    drive(s, 1'b0, 1'b0);
    // BEQ taken and not taken
    s = nop(); s.rd1 = 64'd4; s.rd2 = 64'd4; s.branch = 1'b1; s.ctl = 3'd1;
    s.pc = 64'h100; s.imm = 64'h20;
    drive(s, 1'b0, 1'b0);
    s.rd2 = 64'd5;
    drive(s, 1'b0, 1'b0);
    // JAL during flush: redirect still visible, bubble loaded
    s = nop(); s.jump = 1'b1; s.flush = 1'b1; s.reg_write = 1'b1; s.rd = 5'd1;
    s.pc = 64'h200; s.imm = 64'h40; s.pc4 = 64'h204;
    drive(s, 1'b0, 1'b0);
    // Boundaries: add wrap, signed SLT, maximal shifts, reset mid-stream
    s = nop(); s.rd1 = '1; s.imm = 64'd1; s.alu_src = 1'b1; s.reg_write = 1'b1; s.rd = 5'd7;
    drive(s, 1'b0, 1'b0);
    s = nop(); s.rd1 = 64'h8000_0000_0000_0000; s.rd2 = 64'd1; s.ctl = 3'd5; s.reg_write = 1'b1;
    drive(s, 1'b0, 1'b0);
    s = nop(); s.rd1 = 64'd1; s.imm = 64'hFFC0_0000_0000_003F; s.alu_src = 1'b1; s.ctl = 3'd6;
    s.reg_write = 1'b1;
    drive(s, 1'b0, 1'b0);
    s.rd1 = '1; s.ctl = 3'd7;
    drive(s, 1'b0, 1'b0);
    s = nop(); s.rst_n = 1'b0; s.reg_write = 1'b1; s.rd = 5'd9; s.rd1 = 64'd11;
    drive(s, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) drive(rand_stim(), 1'b0, 1'b0);
`ifdef EXECUTE_MUL_EN
    // MUL 7*6: XLEN+1 stall cycles with bubbles, then the product
    s = nop(); s.mul = 1'b1; s.rd1 = 64'd7; s.rd2 = 64'd6; s.reg_write = 1'b1; s.rd = 5'd9;
    s.pc4 = 64'h304;
    for (int i = 0; i < 65; i++) drive(s, 1'b1, 1'b0);
    drive(s, 1'b0, 1'b1);
    // Abort at RUN cycle 10
    s = nop(); s.mul = 1'b1; s.rd1 = 64'd7; s.rd2 = 64'd6; s.reg_write = 1'b1; s.rd = 5'd9;
    for (int i = 0; i < 11; i++) drive(s, 1'b1, 1'b0);
    s.flush = 1'b1;
    drive(s, 1'b1, 1'b0);
    s = nop(); s.rd1 = 64'd1; s.rd2 = 64'd2; s.reg_write = 1'b1; s.rd = 5'd2;
    drive(s, 1'b0, 1'b0);
    drive(s, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) drive(rand_stim(), 1'b0, 1'b0);
`endif
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
